// File: rtl/wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load-op encodings, stall bit indices, core constants.
// Latency: n/a (declarations only).
// Backpressure: n/a; the stall vector bit positions used by the stage are defined here.
package wb_stage_pkg;

    // Load operation carried from MEM into WB; selects the write-back formatting.
    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5,
        LOAD_LWL  = 3'd6,
        LOAD_LWR  = 3'd7
    } load_op_e;

    // Positions in the 6-bit stall vector produced by ctrl.
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Aligns and extends a big-endian memory word for write-back, including the LWL/LWR merge with old rt.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
// Ports: op (load op), addr_lo (effective address [1:0]), mem (raw word), rt_old (old rt value),
//        result (formatted 32-bit write-back value).
module wb_stage_load_formatter
    import wb_stage_pkg::*;
(
    input  load_op_e    op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Big-endian lanes: address 0 is the most significant byte.
    always_comb begin
        sel_byte = mem[31:24];
        case (addr_lo)
            2'd0: sel_byte = mem[31:24];
            2'd1: sel_byte = mem[23:16];
            2'd2: sel_byte = mem[15:8];
            2'd3: sel_byte = mem[7:0];
            default: sel_byte = mem[31:24];
        endcase
    end

    // Halfword lane uses addr_lo[1] only; misaligned halfwords never reach this stage.
    assign sel_half = addr_lo[1] ? mem[15:0] : mem[31:16];

    always_comb begin
        result = mem;
        case (op)
            LOAD_LB:  result = {{24{sel_byte[7]}}, sel_byte};
            LOAD_LBU: result = {24'h000000, sel_byte};
            LOAD_LH:  result = {{16{sel_half[15]}}, sel_half};
            LOAD_LHU: result = {16'h0000, sel_half};
            LOAD_LWL: begin
                case (addr_lo)
                    2'd0: result = mem;
                    2'd1: result = {mem[23:0], rt_old[7:0]};
                    2'd2: result = {mem[15:0], rt_old[15:0]};
                    2'd3: result = {mem[7:0],  rt_old[23:0]};
                    default: result = mem;
                endcase
            end
            LOAD_LWR: begin
                case (addr_lo)
                    2'd0: result = {rt_old[31:8],  mem[31:24]};
                    2'd1: result = {rt_old[31:16], mem[31:16]};
                    2'd2: result = {rt_old[31:24], mem[31:8]};
                    2'd3: result = mem;
                    default: result = mem;
                endcase
            end
            default: result = mem;    // LOAD_NONE and LOAD_LW pass the word through
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load-data formatting, regfile and HI/LO write ports, retired-instruction count.
// Latency: one cycle from MEM inputs to wb_* outputs; outputs depend only on registered state.
// Backpressure: stall[4] without stall[5] inserts a bubble, both stalled holds, flush kills the MEM slot.
// Ports: clk, rst (sync, active-high); stall, flush; mem_* (MEM-stage results);
//        wb_wreg/wb_wd/wb_wdata (regfile write), wb_whilo/wb_hi/wb_lo (HI/LO write), instret (retire count).
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [31:0]       mem_wdata,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_lo,
    input  logic [31:0]       mem_rt_old,
    input  logic              mem_whilo,
    input  logic [31:0]       mem_hi,
    input  logic [31:0]       mem_lo,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [31:0]       wb_wdata,
    output logic              wb_whilo,
    output logic [31:0]       wb_hi,
    output logic [31:0]       wb_lo,
    output logic [CNT_W-1:0]  instret
);

    // The formatter's lane logic is written for a 32-bit word.
    if (DATA_W != 32) begin : g_data_w_check
        $error("wb_stage: DATA_W must be 32");
    end

    logic              wreg_q;
    logic [ADDR_W-1:0] wd_q;
    logic [31:0]       wdata_q;
    load_op_e          load_op_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       rt_old_q;
    logic              whilo_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [CNT_W-1:0]  instret_q;

    // Stall bits for earlier stages are not relevant here.
    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wreg_q    <= 1'b0;
            wd_q      <= '0;
            wdata_q   <= ZeroWord;
            load_op_q <= LOAD_NONE;
            addr_lo_q <= 2'b00;
            rt_old_q  <= ZeroWord;
            whilo_q   <= 1'b0;
            hi_q      <= ZeroWord;
            lo_q      <= ZeroWord;
            instret_q <= '0;
        end else if (flush || (stall[STALL_MEM] && !stall[STALL_WB])) begin
            // Bubble: nothing is written back and nothing retires.
            wreg_q    <= 1'b0;
            wd_q      <= '0;
            wdata_q   <= ZeroWord;
            load_op_q <= LOAD_NONE;
            addr_lo_q <= 2'b00;
            rt_old_q  <= ZeroWord;
            whilo_q   <= 1'b0;
            hi_q      <= ZeroWord;
            lo_q      <= ZeroWord;
        end else if (!stall[STALL_MEM]) begin
            wreg_q    <= mem_wreg;
            wd_q      <= mem_wd;
            wdata_q   <= mem_wdata;
            load_op_q <= load_op_e'(mem_load_op);
            addr_lo_q <= mem_addr_lo;
            rt_old_q  <= mem_rt_old;
            whilo_q   <= mem_whilo;
            hi_q      <= mem_hi;
            lo_q      <= mem_lo;
            if (mem_valid == WriteEnable) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
        // Both MEM and WB stalled: every register holds.
    end

    wb_stage_load_formatter u_load_formatter (
        .op      (load_op_q),
        .addr_lo (addr_lo_q),
        .mem     (wdata_q),
        .rt_old  (rt_old_q),
        .result  (wb_wdata)
    );

    assign wb_wreg  = wreg_q;
    assign wb_wd    = wd_q;
    assign wb_whilo = whilo_q;
    assign wb_hi    = hi_q;
    assign wb_lo    = lo_q;
    assign instret  = instret_q;

endmodule
